stack_arbiter: RTL and testbench
================================

STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameters: DEPTH (16, entries per stack; power of two); AW (5, shared-RAM address width, equals log2(2*DEPTH)).
REQ-003 Port: Clock, input, 1, sole clock; all logic samples on the rising edge.
REQ-004 Port: Reset, input, 1, synchronous active-high reset.
REQ-005 Port: op_cmd, input, SC_N, operator-stack command (SC_NON/PUS/POP/TOP/CLR); held stable until op_done.
REQ-006 Port: op_wdata, input, CO_N, operator to push.
REQ-007 Port: op_rdata, output, CO_N, operator returned by POP/TOP; valid with op_done.
REQ-008 Port: op_done, output, 1, one-cycle completion pulse.
REQ-009 Port: op_empty, output, 1, operator stack holds 0 entries.
REQ-010 Port: op_full, output, 1, operator stack holds DEPTH entries.
REQ-011 Port: dt_cmd, dt_wdata (CD_N), dt_rdata (CD_N), dt_done, dt_empty, dt_full SHALL be identical to the op_* ports, for the data stack.
REQ-012 Port: err, output, 1, sticky overflow/underflow flag.
REQ-013 Port: mem_addr, output, AW, shared single-port RAM address.
REQ-014 Port: mem_we, output, 1, RAM write enable.
REQ-015 Port: mem_wdata, output, CD_N, RAM write data.
REQ-016 Port: mem_rdata, input, CD_N, RAM read data, one-cycle read latency.

Function
REQ-017 Op stack SHALL occupy addresses 0..DEPTH-1; data stack SHALL occupy DEPTH..2*DEPTH-1.
REQ-018 Each stack SHALL keep a count register 0..DEPTH; push writes at base+count, pop/top read base+count-1.
REQ-019 FSM SHALL have exactly four states: IDLE, ISSUE, RWAIT, DONE.
REQ-020 IDLE: when any requester has cmd != SC_NON, grant one and go to ISSUE next cycle.
REQ-021 Grant order on simultaneous requests SHALL be round-robin; last_grant resets to dt, so op wins the first tie.
REQ-022 ISSUE, PUS: drive mem_we=1 at base+count; op_wdata zero-extended to CD_N; count+1; go to DONE.
REQ-023 ISSUE, POP/TOP: drive read address; go to RWAIT; RWAIT captures mem_rdata (op truncated to CO_N); POP decrements count.
REQ-024 ISSUE, CLR: count=0, no RAM access, clears err; go to DONE.
REQ-025 DONE: pulse the granted requester's done for one cycle; return to IDLE.
REQ-026 Latency from IDLE grant edge SHALL be: PUS/CLR, done 2 cycles later; POP/TOP, done 3 cycles later.
REQ-027 Requester's rdata SHALL hold its last captured value until its next POP/TOP completes.
REQ-028 PUS when full SHALL not write or change count, SHALL set err, and SHALL still pulse done.
REQ-029 POP/TOP when empty SHALL not read, SHALL set err, SHALL return rdata=0, and SHALL still pulse done.
REQ-030 The non-granted requester SHALL wait, with cmd held, without loss.
REQ-031 mem_we SHALL be 0 in every state except ISSUE with a legal PUS.
REQ-032 empty/full SHALL be combinational from count and SHALL update the cycle after the count change.

Reset
REQ-033 Reset SHALL set: state=IDLE, both counts=0, err=0, last_grant=dt, op_rdata=0, dt_rdata=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-034 Reset in any state SHALL abort the operation; no done pulse and no write follow it.
REQ-035 After reset, op_empty=dt_empty=1 and op_full=dt_full=0.

Structure
REQ-036 SC_* command codes, CO_N, CD_N, CO_NO and the FSM state encoding SHALL live in the shared STACK_INTERFACE include; no local redefinition.
REQ-037 The round-robin grant logic SHALL be one sub-module, rr_arbiter2 (two requests, grant, last_grant register).

Verification
REQ-038 Op PUS 5, then op POP -> mem_we at addr 0 with data 5; op_rdata=5 with op_done; op_empty=1 afterwards.
REQ-039 Op PUS and dt PUS asserted in the same cycle after reset -> op is served first (addr 0), then dt (addr 16); each done pulses once.
REQ-040 Fill dt with 16 pushes, then a 17th -> dt_full=1, err=1, no mem_we on the 17th, dt_done pulses; then CLR -> err=0, dt_empty=1.
REQ-041 Op POP on an empty stack -> op_rdata=0, err=1, no RAM read, op_done one cycle.
REQ-042 Dt TOP of 0x1234 twice -> dt_rdata=0x1234 both times; count unchanged; done 3 cycles after each grant.
REQ-043 Reset asserted while in RWAIT -> no done pulse, counts=0, state IDLE next cycle.

Source files
------------

// File: rtl/stack_arbiter_pkg.sv
// Shared stack interface: command codes, payload widths and FSM state encoding.
package stack_arbiter_pkg;

    localparam int unsigned SC_N  = 3;           // command code width
    localparam int unsigned CO_N  = 8;           // operator width
    localparam int unsigned CD_N  = 16;          // data / RAM word width
    localparam int unsigned CO_NO = 1 << CO_N;   // number of distinct operator codes

    localparam logic [SC_N-1:0] SC_NON = 3'd0;
    localparam logic [SC_N-1:0] SC_PUS = 3'd1;
    localparam logic [SC_N-1:0] SC_POP = 3'd2;
    localparam logic [SC_N-1:0] SC_TOP = 3'd3;
    localparam logic [SC_N-1:0] SC_CLR = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RWAIT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/stack_arbiter_rr.sv
// Two-way round-robin arbiter; requester 0 is the operator stack, 1 the data stack.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant_c
);

    logic last_grant;   // 1 = data stack was served last

    // On a tie, favour whoever was not served last.
    always_comb begin
        grant_c = req;
        if (req == 2'b11) begin
            grant_c = last_grant ? 2'b01 : 2'b10;
        end
    end

    // Remember the most recent winner; reset as if the data stack just won.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (advance && (req != 2'b00)) begin
            last_grant <= grant_c[1];
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Two stacks (operator, data) sharing one single-port RAM behind a round-robin FSM.
module stack_arbiter
    import stack_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SC_N-1:0] op_cmd,
    input  logic [CO_N-1:0] op_wdata,
    output logic [CO_N-1:0] op_rdata,
    output logic            op_done,
    output logic            op_empty,
    output logic            op_full,
    input  logic [SC_N-1:0] dt_cmd,
    input  logic [CD_N-1:0] dt_wdata,
    output logic [CD_N-1:0] dt_rdata,
    output logic            dt_done,
    output logic            dt_empty,
    output logic            dt_full,
    output logic            err,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [CD_N-1:0] mem_wdata,
    input  logic [CD_N-1:0] mem_rdata
);

    localparam int unsigned    CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEPTH);
    localparam logic [AW-1:0]  DT_BASE = AW'(DEPTH);

    state_e            state_q, state_d;
    logic              sel_q, sel_d;        // 0 = operator stack, 1 = data stack
    logic [SC_N-1:0]   cmd_q, cmd_d;
    logic              bad_q, bad_d;        // overflow/underflow detected at grant
    logic [CW-1:0]     op_cnt_q, op_cnt_d, dt_cnt_q, dt_cnt_d;
    logic              err_d, op_done_d, dt_done_d, mem_we_d;
    logic [CO_N-1:0]   op_rdata_d;
    logic [CD_N-1:0]   dt_rdata_d, mem_wdata_d, rd_c;
    logic [AW-1:0]     mem_addr_d;
    logic [1:0]        req_c, grant_c;
    logic              g_sel;
    logic [SC_N-1:0]   g_cmd;
    logic [CW-1:0]     g_cnt, cur_cnt, new_cnt;
    logic [CD_N-1:0]   g_wdata;
    logic [AW-1:0]     g_base;
    logic              g_rd;

    // A requester whose done is showing is not re-granted on the same command.
    assign req_c = {(dt_cmd != SC_NON) && !dt_done, (op_cmd != SC_NON) && !op_done};

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_c),
        .advance (state_q == ST_IDLE),
        .grant_c (grant_c)
    );

    // Candidate request selected by the arbiter, plus the active stack's count.
    assign g_sel   = grant_c[1];
    assign g_cmd   = g_sel ? dt_cmd : op_cmd;
    assign g_cnt   = g_sel ? dt_cnt_q : op_cnt_q;
    assign g_wdata = g_sel ? dt_wdata : CD_N'(op_wdata);
    assign g_base  = g_sel ? DT_BASE : AW'(0);
    assign g_rd    = (g_cmd == SC_POP) || (g_cmd == SC_TOP);
    assign cur_cnt = sel_q ? dt_cnt_q : op_cnt_q;
    assign rd_c    = bad_q ? CD_N'(0) : mem_rdata;

    assign op_empty = (op_cnt_q == CW'(0));
    assign op_full  = (op_cnt_q == CNT_MAX);
    assign dt_empty = (dt_cnt_q == CW'(0));
    assign dt_full  = (dt_cnt_q == CNT_MAX);

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cmd_d       = cmd_q;
        bad_d       = bad_q;
        new_cnt     = cur_cnt;
        err_d       = err;
        op_rdata_d  = op_rdata;
        dt_rdata_d  = dt_rdata;
        op_done_d   = 1'b0;
        dt_done_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;

        unique case (state_q)
            ST_IDLE: begin
                if (req_c != 2'b00) begin
                    state_d = ST_ISSUE;
                    sel_d   = g_sel;
                    cmd_d   = g_cmd;
                    bad_d   = ((g_cmd == SC_PUS) && (g_cnt == CNT_MAX)) ||
                              (g_rd && (g_cnt == CW'(0)));
                    if ((g_cmd == SC_PUS) && (g_cnt != CNT_MAX)) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = g_base + AW'(g_cnt);
                        mem_wdata_d = g_wdata;
                    end
                    if (g_rd && (g_cnt != CW'(0))) begin
                        mem_addr_d = g_base + AW'(g_cnt - CW'(1));
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_DONE;
                case (cmd_q)
                    SC_PUS: begin
                        if (bad_q) err_d = 1'b1;
                        else       new_cnt = cur_cnt + CW'(1);
                    end
                    SC_POP, SC_TOP: begin
                        if (bad_q) err_d = 1'b1;
                        state_d = ST_RWAIT;
                    end
                    SC_CLR: begin
                        new_cnt = CW'(0);
                        err_d   = 1'b0;
                    end
                    default: ;
                endcase
            end
            ST_RWAIT: begin
                state_d = ST_DONE;
                if (sel_q) dt_rdata_d = rd_c;
                else       op_rdata_d = CO_N'(rd_c);
                if ((cmd_q == SC_POP) && !bad_q) new_cnt = cur_cnt - CW'(1);
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                op_done_d = !sel_q;
                dt_done_d = sel_q;
            end
            default: state_d = ST_IDLE;
        endcase

        op_cnt_d = sel_q ? op_cnt_q : new_cnt;
        dt_cnt_d = sel_q ? new_cnt : dt_cnt_q;
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= 1'b0;
            cmd_q     <= SC_NON;
            bad_q     <= 1'b0;
            op_cnt_q  <= '0;
            dt_cnt_q  <= '0;
            err       <= 1'b0;
            op_rdata  <= '0;
            dt_rdata  <= '0;
            op_done   <= 1'b0;
            dt_done   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cmd_q     <= cmd_d;
            bad_q     <= bad_d;
            op_cnt_q  <= op_cnt_d;
            dt_cnt_q  <= dt_cnt_d;
            err       <= err_d;
            op_rdata  <= op_rdata_d;
            dt_rdata  <= dt_rdata_d;
            op_done   <= op_done_d;
            dt_done   <= dt_done_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: RAM model, queue-based stack reference, directed and random steps.
module tb_stack_arbiter;
    import stack_arbiter_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [SC_N-1:0] op_cmd, dt_cmd;
    logic [CO_N-1:0] op_wdata, op_rdata;
    logic [CD_N-1:0] dt_wdata, dt_rdata;
    logic            op_done, op_empty, op_full, dt_done, dt_empty, dt_full, err;
    logic [AW-1:0]   mem_addr;
    logic            mem_we;
    logic [CD_N-1:0] mem_wdata, mem_rdata;

    int n_pass  = 0;
    int n_total = 0;

    stack_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .op_cmd(op_cmd), .op_wdata(op_wdata), .op_rdata(op_rdata), .op_done(op_done),
        .op_empty(op_empty), .op_full(op_full),
        .dt_cmd(dt_cmd), .dt_wdata(dt_wdata), .dt_rdata(dt_rdata), .dt_done(dt_done),
        .dt_empty(dt_empty), .dt_full(dt_full),
        .err(err), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one-cycle read latency; every write is logged.
    logic [CD_N-1:0] ram [2*DEPTH];
    logic [AW-1:0]   log_addr[$];
    logic [CD_N-1:0] log_data[$];
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
    end

    // Reference model: one queue per stack (index 0 = bottom).
    logic [CD_N-1:0] q_op[$], q_dt[$];
    logic [AW-1:0]   exp_addr[$];
    logic [CD_N-1:0] exp_data[$];
    logic            m_err;
    logic            m_last;       // 1 = data stack served last
    logic [CO_N-1:0] m_op_rdata;
    logic [CD_N-1:0] m_dt_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int lat(input logic [SC_N-1:0] c);
        return ((c == SC_POP) || (c == SC_TOP)) ? 4 : 3;
    endfunction

    task automatic model_apply(input bit s, input logic [SC_N-1:0] c, input logic [CD_N-1:0] w);
        logic [CD_N-1:0] v;
        int sz;
        v  = s ? w : {8'h00, w[7:0]};
        sz = s ? q_dt.size() : q_op.size();
        if (c == SC_PUS) begin
            if (sz == DEPTH) m_err = 1'b1;
            else begin
                exp_addr.push_back(AW'((s ? DEPTH : 0) + sz));
                exp_data.push_back(v);
                if (s) q_dt.push_back(v); else q_op.push_back(v);
            end
        end else if ((c == SC_POP) || (c == SC_TOP)) begin
            if (sz == 0) begin
                m_err = 1'b1;
                v = '0;
            end else begin
                v = s ? q_dt[sz-1] : q_op[sz-1];
                if (c == SC_POP) begin
                    if (s) void'(q_dt.pop_back()); else void'(q_op.pop_back());
                end
            end
            if (s) m_dt_rdata = v; else m_op_rdata = v[7:0];
        end else if (c == SC_CLR) begin
            if (s) q_dt.delete(); else q_op.delete();
            m_err = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, " op_empty"}, op_empty, q_op.size() == 0);
        check({tag, " op_full"},  op_full,  q_op.size() == DEPTH);
        check({tag, " dt_empty"}, dt_empty, q_dt.size() == 0);
        check({tag, " dt_full"},  dt_full,  q_dt.size() == DEPTH);
        check({tag, " err"},      err,      m_err);
        check({tag, " op_rdata"}, op_rdata, m_op_rdata);
        check({tag, " dt_rdata"}, dt_rdata, m_dt_rdata);
        check({tag, " writes"},   log_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < log_addr.size(); i++) begin
            check($sformatf("%s wr_addr[%0d]", tag, i), log_addr[i], exp_addr[i]);
            check($sformatf("%s wr_data[%0d]", tag, i), log_data[i], exp_data[i]);
        end
        log_addr.delete(); log_data.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        op_cmd = SC_NON; dt_cmd = SC_NON; op_wdata = '0; dt_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        q_op.delete(); q_dt.delete();
        log_addr.delete(); log_data.delete();
        exp_addr.delete(); exp_data.delete();
        m_err = 1'b0; m_last = 1'b1; m_op_rdata = '0; m_dt_rdata = '0;
    endtask

    // Issue one command per requester at once and follow both to completion.
    task automatic run_pair(input string tag, input logic [SC_N-1:0] oc, input logic [CO_N-1:0] ow,
                            input logic [SC_N-1:0] dc, input logic [CD_N-1:0] dw);
        bit has_o, has_d, dt_first;
        int exp_o, exp_d, t_o, t_d, n_o, n_d, horizon;
        has_o = (oc != SC_NON);
        has_d = (dc != SC_NON);
        dt_first = has_d && (!has_o || (m_last == 1'b0));
        exp_o = 0; exp_d = 0; t_o = 0; t_d = 0; n_o = 0; n_d = 0;
        if (dt_first) begin
            model_apply(1'b1, dc, dw);
            exp_d = lat(dc);
            if (has_o) begin
                model_apply(1'b0, oc, {8'h00, ow});
                exp_o = exp_d + lat(oc);
            end
            m_last = !has_o;
        end else if (has_o) begin
            model_apply(1'b0, oc, {8'h00, ow});
            exp_o = lat(oc);
            if (has_d) begin
                model_apply(1'b1, dc, dw);
                exp_d = exp_o + lat(dc);
            end
            m_last = has_d;
        end
        horizon = ((exp_o > exp_d) ? exp_o : exp_d) + 2;
        op_cmd = oc; op_wdata = ow; dt_cmd = dc; dt_wdata = dw;
        for (int k = 1; k <= horizon; k++) begin
            @(negedge clk);
            if (op_done) begin
                n_o++;
                if (n_o == 1) t_o = k;
                op_cmd = SC_NON;
                check({tag, " op_rdata@done"}, op_rdata, m_op_rdata);
            end
            if (dt_done) begin
                n_d++;
                if (n_d == 1) t_d = k;
                dt_cmd = SC_NON;
                check({tag, " dt_rdata@done"}, dt_rdata, m_dt_rdata);
            end
        end
        op_cmd = SC_NON; dt_cmd = SC_NON;
        check({tag, " op_done pulses"}, n_o, has_o);
        check({tag, " dt_done pulses"}, n_d, has_d);
        check({tag, " op_done latency"}, t_o, exp_o);
        check({tag, " dt_done latency"}, t_d, exp_d);
        check_state(tag);
    endtask

    logic [SC_N-1:0] rc_o, rc_d;
    int              n_dn;

    function automatic logic [SC_N-1:0] rand_cmd();
        int r;
        r = $urandom_range(0, 19);
        if (r < 3)  return SC_NON;
        if (r < 10) return SC_PUS;
        if (r < 15) return SC_POP;
        if (r < 19) return SC_TOP;
        return SC_CLR;
    endfunction

    initial begin
        rst = 1'b1;
        op_cmd = SC_NON; dt_cmd = SC_NON; op_wdata = '0; dt_wdata = '0;
        do_reset();

        // Reset values.
        check("rst op_done", op_done, 1'b0);
        check("rst dt_done", dt_done, 1'b0);
        check("rst mem_we", mem_we, 1'b0);
        check("rst mem_addr", mem_addr, '0);
        check("rst mem_wdata", mem_wdata, '0);
        check_state("rst");

        // Operator push then pop.
        run_pair("op_push5", SC_PUS, 8'd5, SC_NON, '0);
        run_pair("op_pop5", SC_POP, '0, SC_NON, '0);

        // Simultaneous pushes straight after reset: operator wins the first tie.
        do_reset();
        run_pair("tie_push", SC_PUS, 8'h21, SC_PUS, 16'hbeef);
        run_pair("tie_pop", SC_POP, '0, SC_POP, '0);

        // Fill the data stack, overflow it, then clear.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            run_pair($sformatf("fill%0d", i), SC_NON, '0, SC_PUS, CD_N'($urandom));
        end
        run_pair("overflow", SC_NON, '0, SC_PUS, 16'h7777);
        run_pair("clr_dt", SC_NON, '0, SC_CLR, '0);

        // Underflow on the empty operator stack.
        run_pair("op_underflow", SC_POP, '0, SC_NON, '0);
        run_pair("op_clr", SC_CLR, '0, SC_NON, '0);

        // TOP twice returns the same word without consuming it.
        run_pair("dt_push1234", SC_NON, '0, SC_PUS, 16'h1234);
        run_pair("dt_top_a", SC_NON, '0, SC_TOP, '0);
        run_pair("dt_top_b", SC_NON, '0, SC_TOP, '0);

        // Reset while a data pop waits for RAM data.
        @(negedge clk);
        dt_cmd = SC_POP;
        @(negedge clk);             // grant edge passed: ISSUE
        @(negedge clk);             // now in RWAIT
        rst = 1'b1;
        dt_cmd = SC_NON;
        @(negedge clk);
        rst = 1'b0;
        q_op.delete(); q_dt.delete();
        log_addr.delete(); log_data.delete();
        exp_addr.delete(); exp_data.delete();
        m_err = 1'b0; m_last = 1'b1; m_op_rdata = '0; m_dt_rdata = '0;
        n_dn = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (op_done || dt_done) n_dn++;
        end
        check("abort done pulses", n_dn, 0);
        check_state("abort");
        run_pair("after_abort", SC_PUS, 8'h3c, SC_NON, '0);

        // Randomised traffic on both requesters.
        for (int i = 0; i < 200; i++) begin
            rc_o = rand_cmd();
            rc_d = rand_cmd();
            run_pair($sformatf("rnd%0d", i), rc_o, CO_N'($urandom), rc_d, CD_N'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
